// File: rtl/mul_arbiter.sv
// rtl/mul_arbiter.sv - round-robin sharing of one pipelined 33x33 multiplier core between two issue pipes
// Define MUL_ARB_PERF_EN to build the saturating perf_conflict/perf_stall counters.
package mul_arbiter_pkg;
  typedef enum logic [1:0] {
    MUL_MUL   = 2'd0,
    MUL_MULH  = 2'd1,
    MUL_MULHU = 2'd2
  } mul_opcode_t;
endpackage

module mul_arbiter
  import mul_arbiter_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int TAG_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  mul_opcode_t [1:0]     req_opcode,
  input  logic [1:0][31:0]      req_src1,
  input  logic [1:0][31:0]      req_src2,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic [32:0]           mul_a,
  output logic [32:0]           mul_b,
  output logic                  mul_ce,
  input  logic [63:0]           mul_p,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [TAG_W-1:0]      resp_tag,
  output logic [31:0]           resp_data,
  output logic [31:0]           perf_conflict,
  output logic [31:0]           perf_stall
);

  logic [LAT-1:0]   st_vld;
  logic [LAT-1:0]   st_id;
  logic [LAT-1:0]   st_hi;
  logic [TAG_W-1:0] st_tag [LAT];

  logic last_gnt;
  logic stall;
  logic advance;
  logic gnt;
  logic pick;
  logic sel;
  logic sx;

  assign stall   = st_vld[LAT-1] & ~resp_ready;
  assign advance = ~stall | flush;
  assign mul_ce  = advance;

  // Contention goes to the pipe that was not granted last.
  always_comb begin
    gnt  = 1'b0;
    pick = 1'b0;
    if (!stall && !flush && !reset) begin
      case (req_valid)
        2'b01:   begin gnt = 1'b1; pick = 1'b0;      end
        2'b10:   begin gnt = 1'b1; pick = 1'b1;      end
        2'b11:   begin gnt = 1'b1; pick = ~last_gnt; end
        default: begin gnt = 1'b0; pick = 1'b0;      end
      endcase
    end
  end

  assign req_ready = gnt ? (pick ? 2'b10 : 2'b01) : 2'b00;
  assign sel       = gnt & pick;

  // Only signed-high needs a sign-extended 33rd bit; the low half is identical either way.
  assign sx    = (req_opcode[sel] == MUL_MULH);
  assign mul_a = {sx & req_src1[sel][31], req_src1[sel]};
  assign mul_b = {sx & req_src2[sel][31], req_src2[sel]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_vld   <= '0;
      last_gnt <= 1'b1;
    end else begin
      if (gnt) last_gnt <= pick;
      if (flush) begin
        st_vld <= '0;
      end else if (advance) begin
        for (int i = LAT - 1; i > 0; i--) st_vld[i] <= st_vld[i-1];
        st_vld[0] <= gnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int i = LAT - 1; i > 0; i--) begin
        st_id[i]  <= st_id[i-1];
        st_hi[i]  <= st_hi[i-1];
        st_tag[i] <= st_tag[i-1];
      end
      st_id[0]  <= sel;
      st_hi[0]  <= (req_opcode[sel] != MUL_MUL);
      st_tag[0] <= req_tag[sel];
    end
  end

  assign resp_valid = st_vld[LAT-1];
  assign resp_id    = st_id[LAT-1];
  assign resp_tag   = st_tag[LAT-1];
  assign resp_data  = st_hi[LAT-1] ? mul_p[63:32] : mul_p[31:0];

`ifdef MUL_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_conflict <= '0;
      perf_stall    <= '0;
    end else begin
      if ((&req_valid) && (perf_conflict != 32'hFFFF_FFFF)) perf_conflict <= perf_conflict + 32'd1;
      if (stall && (perf_stall != 32'hFFFF_FFFF))          perf_stall    <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_conflict = 32'h0;
  assign perf_stall    = 32'h0;
`endif

endmodule
